// File: rtl/display_frame_seq_if.sv
// Frame-sequencer handshake bundle: request/configuration from the master,
// frame data plus status back from the sequencer.
interface display_frame_seq_if #(
    parameter int NB_SEGMENTS = 56,
    parameter int RNDSIZE     = 16,
    parameter int FRAME_CNT_W = 8
);
    logic                   start;
    logic                   z;
    logic [NB_SEGMENTS-1:0] msg;
    logic [RNDSIZE-1:0]     rnd;
    logic [3:0]             probability;
    logic [FRAME_CNT_W-1:0] nframes;
    logic [NB_SEGMENTS-1:0] selseg;
    logic                   out_valid;
    logic                   out_ready;
    logic [FRAME_CNT_W-1:0] frame_idx;
    logic                   busy;
    logic                   done;

    modport master (
        output start, z, msg, rnd, probability, nframes, out_ready,
        input  selseg, out_valid, frame_idx, busy, done
    );

    modport slave (
        input  start, z, msg, rnd, probability, nframes, out_ready,
        output selseg, out_valid, frame_idx, busy, done
    );
endinterface

// File: rtl/display_frame_seq.sv
// Builds NB_SEGMENTS-wide random-thinned message frames, one segment per cycle,
// and holds each frame on a valid/ready output until accepted.
module display_frame_seq #(
    parameter int NB_SEGMENTS = 56,
    parameter int RNDSIZE     = 16,
    parameter int FRAME_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    display_frame_seq_if.slave bus
);
    localparam int SEG_W = (NB_SEGMENTS > 1) ? $clog2(NB_SEGMENTS) : 1;
    localparam logic [SEG_W-1:0]   SEG_LAST = SEG_W'(NB_SEGMENTS - 1);
    localparam logic [RNDSIZE-1:0] SEED_DEF = RNDSIZE'(16'hACE1);

    typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NB_SEGMENTS-1:0] msg_r;
    logic                   z_r;
    logic [3:0]             prob_r;
    logic [FRAME_CNT_W-1:0] nframes_r;
    logic [RNDSIZE-1:0]     lfsr;
    logic [RNDSIZE-1:0]     lfsr_adv;
    logic [SEG_W-1:0]       seg_cnt;
    logic [NB_SEGMENTS-1:0] selseg_r;
    logic [FRAME_CNT_W-1:0] frame_idx_r;
    logic                   done_r;
    logic                   seg_keep;
    logic                   seg_last;
    logic                   frame_last;

    function automatic logic [RNDSIZE-1:0] lfsr_step(input logic [RNDSIZE-1:0] s);
        return {s[RNDSIZE-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign lfsr_adv   = lfsr_step(lfsr_step(lfsr_step(lfsr_step(lfsr))));
    assign seg_keep   = z_r & msg_r[seg_cnt] & (lfsr_adv[3:0] >= prob_r);
    assign seg_last   = (seg_cnt == SEG_LAST);
    // nframes==0 wraps to all-ones here, giving the full 2^FRAME_CNT_W frames
    assign frame_last = (frame_idx_r == (nframes_r - FRAME_CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start)     state_nxt = GEN;
            GEN:     if (seg_last)      state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = frame_last ? IDLE : GEN;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == OUT);
        bus.busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_r       <= '0;
            z_r         <= 1'b0;
            prob_r      <= '0;
            nframes_r   <= '0;
            lfsr        <= SEED_DEF;
            seg_cnt     <= '0;
            selseg_r    <= '0;
            frame_idx_r <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: if (bus.start) begin
                    msg_r       <= bus.msg;
                    z_r         <= bus.z;
                    prob_r      <= bus.probability;
                    nframes_r   <= bus.nframes;
                    lfsr        <= (bus.rnd == '0) ? SEED_DEF : bus.rnd;
                    seg_cnt     <= '0;
                    selseg_r    <= '0;
                    frame_idx_r <= '0;
                end
                GEN: begin
                    lfsr              <= lfsr_adv;
                    selseg_r[seg_cnt] <= seg_keep;
                    seg_cnt           <= seg_last ? '0 : seg_cnt + SEG_W'(1);
                end
                OUT: if (bus.out_ready) begin
                    if (frame_last) begin
                        done_r <= 1'b1;
                    end else begin
                        frame_idx_r <= frame_idx_r + FRAME_CNT_W'(1);
                        selseg_r    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.selseg    = selseg_r;
    assign bus.frame_idx = frame_idx_r;
    assign bus.done      = done_r;
endmodule
